reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
In-order retirement buffer on the responder side of the dispatch allocation interface. Dispatch allocates one entry per cycle at the tail and receives the entry's ROB id. Execution units mark entries done by id over the completion bus. Entries retire in program order from the head to the commit consumer (free list / architectural map).

Parameters:
DEPTH, 16, number of entries; power of two, at least 4
PREG_W, 7, physical register index width
AREG_W, 5, architectural register index width
ID_W, $clog2(DEPTH), ROB id width (4 at the default depth)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
alloc_valid  in  1  dispatch requests an allocation
alloc_ready  out  1  an entry is available
alloc_id  out  ID_W  id the next allocation receives (tail)
alloc_has_dest  in  1  instruction writes a register
alloc_a_dest  in  AREG_W  architectural destination
alloc_p_dest  in  PREG_W  new physical destination
alloc_p_old  in  PREG_W  previous mapping of a_dest
alloc_is_store  in  1  store instruction
cdb_valid  in  1  completion broadcast
cdb_rob_id  in  ID_W  id of the completed entry
commit_valid  out  1  head entry is ready to retire
commit_ready  in  1  consumer accepts the retirement
commit_rob_id  out  ID_W  head id
commit_has_dest, commit_a_dest, commit_p_dest, commit_p_old, commit_is_store  out  1/AREG_W/PREG_W/PREG_W/1  head entry fields
count  out  ID_W+1  occupied entries

Behaviour:
- Reset is asynchronous and active-high, with one clock.
- Pointers:
  - head and tail are ID_W+1 bits; the MSB is the wrap bit.
  - empty when head==tail.
  - full when the low bits are equal and the MSBs differ.
- Per-entry state is a valid bit, a done bit and the payload.
- On reset:
  - head=tail=0, all valid/done bits cleared.
  - Outputs: alloc_ready=1, alloc_id=0, commit_valid=0, count=0, commit_* fields 0.
- alloc_ready = !full, decoded from registers only; it never depends on alloc_valid or commit_ready.
- alloc_id = tail[ID_W-1:0] at all times.
- Allocation fires on alloc_valid&&alloc_ready:
  - Writes the payload at tail, sets valid=1 and done=0, tail increments.
  - The entry is visible to completion the next cycle.
- Completion:
  - cdb_valid with valid[cdb_rob_id]=1 sets done the next cycle.
  - Completion to an invalid entry is ignored.
  - Completion of an already-done entry has no effect.
- Commit:
  - commit_valid = valid[head]&&done[head], from registers.
  - Fires on commit_valid&&commit_ready: clears valid[head], head increments.
  - commit_* outputs are the head entry fields.
- Latency:
  - Completion of the head entry raises commit_valid on the following cycle.
  - Commit throughput is one entry per cycle.
- Simultaneous events:
  - Allocation and commit in the same cycle are both performed.
  - When full, allocation is blocked even if a commit fires that cycle; alloc_ready returns the next cycle.
  - Completion and commit of different entries in the same cycle are independent.
- count = tail-head, modulo 2^(ID_W+1).
- Wrap-around: pointers wrap naturally; ids reused after wrap are distinguished only by the valid bit.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
Macro ROB_FLUSH_EN adds flush_valid (in, 1) and flush_rob_id (in, ID_W) for branch-mispredict recovery.
- The flushed entry itself is kept.
- All entries younger than it are invalidated.
- tail <= head + ((flush_rob_id - head[ID_W-1:0]) mod DEPTH) + 1, with the correct wrap bit.
- Priority and gating:
  - Flush has priority over allocation; alloc_ready is forced to 0 while flush_valid is high.
  - A same-cycle commit still fires.
  - A same-cycle completion to a flushed entry is dropped.
  - A flush naming an invalid entry is ignored.

Without ROB_FLUSH_EN the ports do not exist and the tail only ever advances.

Decomposition:
Package rob_pkg holds:
- constants ROB_DEPTH and ROB_ID_W
- typedef rob_id_t
- typedef rob_ptr_t (ID_W+1 bits)
- typedef rob_entry_t (has_dest, a_dest, p_dest, p_old, is_store)

Dispatch and the execution units import rob_id_t from it. No sub-module: storage and pointer logic stay inline.

Test Plan:
- Reset, then 16 allocations with commit_ready=0 and no completions -> alloc_id runs 0..15; alloc_ready=0 and count=16 after the 16th; commit_valid stays 0.
- Complete ids 2, 1, 0 in consecutive cycles -> commit_valid rises the cycle after id 0 completes; ids 0, 1, 2 commit in order on consecutive cycles.
- Full ROB, complete the head and hold alloc_valid=1 -> commit fires with alloc blocked that cycle; alloc_ready=1 the next cycle; the next alloc receives id 0 (wrapped).
- Completion to an invalid id 9 with an empty ROB -> no state change; count=0; commit_valid=0.
- 40 random allocations/completions with pointer wrap -> commit order equals allocation order; p_old values match; count never exceeds 16.
- (ROB_FLUSH_EN) Allocate ids 0..7, flush id 3 -> count=4; alloc_id=4; completions to ids 5 and 6 are ignored; ids 0..3 commit normally.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types: id/pointer widths and the retirement payload record.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Dispatch and execution units import rob_id_t from here.
package rob_pkg;
   localparam int ROB_DEPTH  = 16;
   localparam int ROB_ID_W   = $clog2(ROB_DEPTH);
   localparam int ROB_PREG_W = 7;
   localparam int ROB_AREG_W = 5;

   typedef logic [ROB_ID_W-1:0] rob_id_t;
   typedef logic [ROB_ID_W:0]   rob_ptr_t;   // MSB is the wrap bit

   typedef struct packed {
      logic                  has_dest;
      logic [ROB_AREG_W-1:0] a_dest;
      logic [ROB_PREG_W-1:0] p_dest;
      logic [ROB_PREG_W-1:0] p_old;
      logic                  is_store;
   } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / commit bundle between the ROB and its neighbours.
// Latency: n/a (wiring only). ROB_FLUSH_EN adds the flush_valid/flush_rob_id pair.
// Backpressure: alloc via alloc_ready, commit via commit_ready; cdb and flush are unthrottled.
interface reorder_buffer_if
   import rob_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int PREG_W = ROB_PREG_W,
   parameter int AREG_W = ROB_AREG_W,
   parameter int ID_W   = $clog2(DEPTH)
) ();
   logic              alloc_valid;
   logic              alloc_ready;
   logic [ID_W-1:0]   alloc_id;
   logic              alloc_has_dest;
   logic [AREG_W-1:0] alloc_a_dest;
   logic [PREG_W-1:0] alloc_p_dest;
   logic [PREG_W-1:0] alloc_p_old;
   logic              alloc_is_store;
   logic              cdb_valid;
   logic [ID_W-1:0]   cdb_rob_id;
   logic              commit_valid;
   logic              commit_ready;
   logic [ID_W-1:0]   commit_rob_id;
   logic              commit_has_dest;
   logic [AREG_W-1:0] commit_a_dest;
   logic [PREG_W-1:0] commit_p_dest;
   logic [PREG_W-1:0] commit_p_old;
   logic              commit_is_store;
   logic [ID_W:0]     count;
`ifdef ROB_FLUSH_EN
   logic              flush_valid;
   logic [ID_W-1:0]   flush_rob_id;
`endif

   // ROB side
   modport slave (
`ifdef ROB_FLUSH_EN
      input  flush_valid, flush_rob_id,
`endif
      input  alloc_valid, alloc_has_dest, alloc_a_dest, alloc_p_dest, alloc_p_old,
             alloc_is_store, cdb_valid, cdb_rob_id, commit_ready,
      output alloc_ready, alloc_id, commit_valid, commit_rob_id, commit_has_dest,
             commit_a_dest, commit_p_dest, commit_p_old, commit_is_store, count
   );

   // Dispatch / execution / commit-consumer side
   modport master (
`ifdef ROB_FLUSH_EN
      output flush_valid, flush_rob_id,
`endif
      output alloc_valid, alloc_has_dest, alloc_a_dest, alloc_p_dest, alloc_p_old,
             alloc_is_store, cdb_valid, cdb_rob_id, commit_ready,
      input  alloc_ready, alloc_id, commit_valid, commit_rob_id, commit_has_dest,
             commit_a_dest, commit_p_dest, commit_p_old, commit_is_store, count
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete by id, retire from head.
// Latency: completion -> commit_valid 1 cycle; one commit per cycle. ROB_FLUSH_EN enables flush.
// Backpressure: alloc_ready = !full (and no flush); commit holds until commit_ready.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int PREG_W = ROB_PREG_W,
   parameter int AREG_W = ROB_AREG_W,
   parameter int ID_W   = $clog2(DEPTH)
) (
   input logic              clk,
   input logic              reset,
   reorder_buffer_if.slave  rob
);
   typedef struct packed {
      logic              has_dest;
      logic [AREG_W-1:0] a_dest;
      logic [PREG_W-1:0] p_dest;
      logic [PREG_W-1:0] p_old;
      logic              is_store;
   } entry_t;

   logic [ID_W:0]    head, tail;
   logic [DEPTH-1:0] valid, done;
   entry_t           payload [DEPTH];

   logic [ID_W-1:0]  head_idx, tail_idx;
   logic             full, alloc_fire, commit_fire, cdb_hit;
   logic             flush_do;
   logic [ID_W:0]    flush_tail;
   logic [DEPTH-1:0] flush_kill;

   assign head_idx = head[ID_W-1:0];
   assign tail_idx = tail[ID_W-1:0];
   assign full     = (head_idx == tail_idx) && (head[ID_W] != tail[ID_W]);

`ifdef ROB_FLUSH_EN
   logic [ID_W-1:0] flush_dist;
   // Flush keeps the named entry and kills everything younger; tail snaps to just past it.
   always_comb begin
      logic [ID_W-1:0] rel;
      rel        = '0;
      flush_do   = rob.flush_valid && valid[rob.flush_rob_id];
      flush_dist = rob.flush_rob_id - head_idx;
      flush_tail = head + {1'b0, flush_dist} + (ID_W+1)'(1);
      flush_kill = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rel = ID_W'(i) - head_idx;
         if (flush_do && (rel > flush_dist)) flush_kill[i] = 1'b1;
      end
   end
   assign rob.alloc_ready = !full && !rob.flush_valid;
`else
   assign flush_do        = 1'b0;
   assign flush_tail      = tail;
   assign flush_kill      = '0;
   assign rob.alloc_ready = !full;
`endif

   assign alloc_fire  = rob.alloc_valid && rob.alloc_ready;
   assign commit_fire = rob.commit_valid && rob.commit_ready;
   // Completions only land on live entries; a flush in the same cycle wins.
   assign cdb_hit     = rob.cdb_valid && valid[rob.cdb_rob_id] && !flush_kill[rob.cdb_rob_id];

   assign rob.alloc_id        = tail_idx;
   assign rob.count           = tail - head;
   assign rob.commit_valid    = valid[head_idx] && done[head_idx];
   assign rob.commit_rob_id   = head_idx;
   assign rob.commit_has_dest = payload[head_idx].has_dest;
   assign rob.commit_a_dest   = payload[head_idx].a_dest;
   assign rob.commit_p_dest   = payload[head_idx].p_dest;
   assign rob.commit_p_old    = payload[head_idx].p_old;
   assign rob.commit_is_store = payload[head_idx].is_store;

   // Head advances on retirement; tail advances on allocation or is pulled back by flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (commit_fire) head <= head + (ID_W+1)'(1);
         if (flush_do) tail <= flush_tail;
         else if (alloc_fire) tail <= tail + (ID_W+1)'(1);
      end
   end

   // Per-entry valid/done/payload updates; alloc and commit never target the same slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid[i]   <= 1'b0;
            done[i]    <= 1'b0;
            payload[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_fire && (tail_idx == ID_W'(i))) begin
               valid[i]   <= 1'b1;
               done[i]    <= 1'b0;
               payload[i] <= '{has_dest: rob.alloc_has_dest, a_dest: rob.alloc_a_dest,
                               p_dest: rob.alloc_p_dest, p_old: rob.alloc_p_old,
                               is_store: rob.alloc_is_store};
            end else begin
               if ((commit_fire && (head_idx == ID_W'(i))) || flush_kill[i]) valid[i] <= 1'b0;
               if (cdb_hit && (rob.cdb_rob_id == ID_W'(i))) done[i] <= 1'b1;
            end
         end
      end
   end
endmodule
